// File: rtl/sm_rd_mux_pkg.sv
// Shared types for the shared-memory read multiplexer: owner index and channel limits.
package sm_rd_mux_pkg;

    localparam int unsigned SM_RD_MUX_MAX_CH = 16;
    localparam int unsigned OWN_W            = $clog2(SM_RD_MUX_MAX_CH);

    typedef logic [OWN_W-1:0] own_idx_t;

    // Successor of a channel index, wrapping at ch_cnt
    function automatic own_idx_t rr_next(input own_idx_t idx, input int unsigned ch_cnt);
        return (32'(idx) == ch_cnt - 1) ? '0 : idx + OWN_W'(1);
    endfunction

endpackage

// File: rtl/sm_rr_arb.sv
// Parametrised round-robin arbiter: one-hot grant plus index, search starts at the
// internal pointer, pointer moves past the winner when i_upd is high.
module sm_rr_arb
    import sm_rd_mux_pkg::*;
#(
    parameter int unsigned CH_CNT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CH_CNT-1:0] i_req,
    input  logic              i_en,
    input  logic              i_upd,
    output logic [CH_CNT-1:0] o_gnt_c,
    output own_idx_t          o_gnt_idx_c,
    output logic              o_gnt_vld_c
);

    localparam int unsigned SUM_W = OWN_W + 1;

    own_idx_t              r_ptr;
    logic [2*CH_CNT-1:0]   w_dbl;
    logic [CH_CNT-1:0]     w_rot;
    logic [SUM_W-1:0]      w_sum;

    // Rotate requests so bit 0 is the pointer channel, then take the first set bit
    always_comb begin
        w_dbl       = {i_req, i_req};
        w_rot       = CH_CNT'(w_dbl >> r_ptr);
        w_sum       = '0;
        o_gnt_vld_c = 1'b0;
        o_gnt_idx_c = '0;
        o_gnt_c     = '0;
        for (int unsigned k = 0; k < CH_CNT; k++) begin
            if (i_en && !o_gnt_vld_c && w_rot[k]) begin
                o_gnt_vld_c = 1'b1;
                w_sum       = {1'b0, r_ptr} + SUM_W'(k);
                o_gnt_idx_c = (32'(w_sum) >= CH_CNT) ? OWN_W'(32'(w_sum) - CH_CNT)
                                                     : OWN_W'(w_sum);
            end
        end
        for (int unsigned i = 0; i < CH_CNT; i++) begin
            o_gnt_c[i] = o_gnt_vld_c && (o_gnt_idx_c == OWN_W'(i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (i_upd && o_gnt_vld_c) begin
            r_ptr <= rr_next(o_gnt_idx_c, CH_CNT);
        end
    end

endmodule

// File: rtl/sm_rd_mux.sv
// N-client read multiplexer in front of sm_top: round-robin command merge, owner FIFO,
// packet return routing. Optional protocol checker enabled by SM_RD_MUX_PROT_CHECK_EN.
module sm_rd_mux
    import sm_rd_mux_pkg::*;
#(
    parameter  int unsigned CH_CNT     = 4,
    parameter  int unsigned CMD_W      = 16,
    parameter  int unsigned AST_DATA_W = 32,
    parameter  int unsigned OUTST      = 4,
    localparam int unsigned EMPTY_W    = (AST_DATA_W / 8 > 1) ? $clog2(AST_DATA_W / 8) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CH_CNT*CMD_W-1:0] s_cmd_data_i,
    input  logic [CH_CNT-1:0]       s_cmd_valid_i,
    output logic [CH_CNT-1:0]       s_cmd_ready_o,
    output logic [CMD_W-1:0]        m_cmd_data_o,
    output logic                    m_cmd_valid_o,
    input  logic                    m_cmd_ready_i,
    input  logic [AST_DATA_W-1:0]   m_src_data_i,
    input  logic                    m_src_valid_i,
    input  logic                    m_src_sop_i,
    input  logic                    m_src_eop_i,
    input  logic [EMPTY_W-1:0]      m_src_empty_i,
    output logic                    m_src_ready_o,
    output logic [AST_DATA_W-1:0]   s_src_data_o,
    output logic                    s_src_sop_o,
    output logic                    s_src_eop_o,
    output logic [EMPTY_W-1:0]      s_src_empty_o,
    output logic [CH_CNT-1:0]       s_src_valid_o,
    input  logic [CH_CNT-1:0]       s_src_ready_i,
    output logic                    err_o
);

    localparam int unsigned PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(OUTST + 1);

    logic [CMD_W-1:0]  r_cmd_data;
    logic              r_cmd_valid;
    own_idx_t          r_own_mem [OUTST];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_load_en;
    logic [CH_CNT-1:0] w_gnt;
    own_idx_t          w_gnt_idx;
    logic              w_gnt_vld;
    logic              w_push;
    logic              w_pop;
    own_idx_t          w_own;
    logic [CMD_W-1:0]  w_sel_data;
    logic              w_src_ready;

    assign w_fifo_full  = (r_cnt == CNT_W'(OUTST));
    assign w_fifo_empty = (r_cnt == '0);
    assign w_load_en    = (!r_cmd_valid || m_cmd_ready_i) && !w_fifo_full;
    assign w_push       = w_gnt_vld;
    assign w_own        = r_own_mem[r_rd_ptr];

    sm_rr_arb #(
        .CH_CNT (CH_CNT)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_req       (s_cmd_valid_i),
        .i_en        (w_load_en),
        .i_upd       (w_push),
        .o_gnt_c     (w_gnt),
        .o_gnt_idx_c (w_gnt_idx),
        .o_gnt_vld_c (w_gnt_vld)
    );

    assign s_cmd_ready_o = w_gnt;

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < CH_CNT; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = s_cmd_data_i[i*CMD_W +: CMD_W];
            end
        end
    end

    // A consumed command is dropped even while the owner FIFO blocks new grants
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
        end else if (w_load_en) begin
            r_cmd_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_cmd_data <= w_sel_data;
            end
        end else if (m_cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
        end
    end

    assign m_cmd_valid_o = r_cmd_valid;
    assign m_cmd_data_o  = r_cmd_data;

    // Return routing towards the FIFO head owner
    always_comb begin
        s_src_valid_o = '0;
        w_src_ready   = 1'b0;
        for (int unsigned i = 0; i < CH_CNT; i++) begin
            if (w_own == OWN_W'(i)) begin
                s_src_valid_o[i] = m_src_valid_i && !w_fifo_empty;
                w_src_ready      = s_src_ready_i[i] && !w_fifo_empty;
            end
        end
    end

    assign m_src_ready_o = w_src_ready;
    assign w_pop         = m_src_valid_i && w_src_ready && m_src_eop_i;
    assign s_src_data_o  = m_src_data_i;
    assign s_src_sop_o   = m_src_sop_i;
    assign s_src_eop_o   = m_src_eop_i;
    assign s_src_empty_o = m_src_empty_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int unsigned i = 0; i < OUTST; i++) begin
                r_own_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_own_mem[r_wr_ptr] <= w_gnt_idx;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(OUTST - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(OUTST - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

`ifdef SM_RD_MUX_PROT_CHECK_EN
    logic r_in_pkt;
    logic r_err;
    logic w_beat;
    logic w_viol;

    assign w_beat = m_src_valid_i && w_src_ready;
    assign w_viol = (m_src_valid_i && w_fifo_empty)
                 || (w_beat && !r_in_pkt && !m_src_sop_i)
                 || (w_beat &&  r_in_pkt &&  m_src_sop_i)
                 || (w_beat && !m_src_eop_i && (m_src_empty_i != '0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_pkt <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_beat) begin
                r_in_pkt <= !m_src_eop_i;
            end
            if (w_viol) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sm_rd_mux.sv
// Directed bench for sm_rd_mux with default parameters (4 channels, 16-bit commands, 4 outstanding).
module tb_sm_rd_mux;

    logic        clk;
    logic        rst;
    logic [63:0] s_cmd_data;
    logic [3:0]  s_cmd_valid;
    logic [3:0]  s_cmd_ready;
    logic [15:0] m_cmd_data;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [31:0] m_src_data;
    logic        m_src_valid;
    logic        m_src_sop;
    logic        m_src_eop;
    logic [1:0]  m_src_empty;
    logic        m_src_ready;
    logic [31:0] s_src_data;
    logic        s_src_sop;
    logic        s_src_eop;
    logic [1:0]  s_src_empty;
    logic [3:0]  s_src_valid;
    logic [3:0]  s_src_ready;
    logic        err;

    int checks;
    int errors;

`ifdef SM_RD_MUX_PROT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    sm_rd_mux dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s_cmd_data_i  (s_cmd_data),
        .s_cmd_valid_i (s_cmd_valid),
        .s_cmd_ready_o (s_cmd_ready),
        .m_cmd_data_o  (m_cmd_data),
        .m_cmd_valid_o (m_cmd_valid),
        .m_cmd_ready_i (m_cmd_ready),
        .m_src_data_i  (m_src_data),
        .m_src_valid_i (m_src_valid),
        .m_src_sop_i   (m_src_sop),
        .m_src_eop_i   (m_src_eop),
        .m_src_empty_i (m_src_empty),
        .m_src_ready_o (m_src_ready),
        .s_src_data_o  (s_src_data),
        .s_src_sop_o   (s_src_sop),
        .s_src_eop_o   (s_src_eop),
        .s_src_empty_o (s_src_empty),
        .s_src_valid_o (s_src_valid),
        .s_src_ready_i (s_src_ready),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int ch, input logic [15:0] d);
        s_cmd_data[ch*16 +: 16] = d;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic src_idle();
        m_src_valid = 1'b0;
        m_src_sop   = 1'b0;
        m_src_eop   = 1'b0;
        m_src_empty = 2'd0;
        m_src_data  = 32'd0;
    endtask

    logic [3:0] drain_own [4];
    logic       rdy_pat   [7];
    int         b;

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        s_cmd_data  = 64'd0;
        s_cmd_valid = 4'd0;
        m_cmd_ready = 1'b1;
        s_src_ready = 4'hF;
        src_idle();
        drain_own = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rdy_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cmd_valid", 64'(m_cmd_valid), 64'd0);
        chk("rst_cmd_data",  64'(m_cmd_data),  64'd0);
        chk("rst_err",       64'(err),         64'd0);
        chk("rst_src_ready", 64'(m_src_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ch1 command 0x0012, 3-beat return
        set_cmd(1, 16'h0012);
        s_cmd_valid = 4'b0010;
        #1;
        chk("t1_cmd_ready", 64'(s_cmd_ready), 64'h2);
        chk("t1_cmd_valid_pre", 64'(m_cmd_valid), 64'd0);
        @(negedge clk);
        s_cmd_valid = 4'b0000;
        #1;
        chk("t1_cmd_valid", 64'(m_cmd_valid), 64'd1);
        chk("t1_cmd_data",  64'(m_cmd_data),  64'h0012);
        for (int i = 0; i < 3; i++) begin
            m_src_valid = 1'b1;
            m_src_data  = 32'hA000_0000 + 32'(i);
            m_src_sop   = (i == 0);
            m_src_eop   = (i == 2);
            m_src_empty = (i == 2) ? 2'd1 : 2'd0;
            #1;
            chk("t1_src_valid", 64'(s_src_valid), 64'h2);
            chk("t1_src_ready", 64'(m_src_ready), 64'd1);
            chk("t1_src_data",  64'(s_src_data),  64'hA000_0000 + 64'(i));
            @(negedge clk);
        end
        chk("t1_src_empty_last", 64'(s_src_empty), 64'd1);
        src_idle();
        #1;
        chk("t1_fifo_empty", 64'(m_src_ready), 64'd0);
        chk("t1_cmd_drained", 64'(m_cmd_valid), 64'd0);

        // All channels valid: grants 0,1,2,3 then stall at 4 outstanding
        pulse_reset();
        for (int i = 0; i < 4; i++) set_cmd(i, 16'h0100 + 16'(i));
        s_cmd_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_grant", 64'(s_cmd_ready), 64'(4'b0001 << k));
            @(negedge clk);
            chk("t2_cmd_data", 64'(m_cmd_data), 64'h0100 + 64'(k));
            chk("t2_cmd_valid", 64'(m_cmd_valid), 64'd1);
        end
        #1;
        chk("t2_full_ready", 64'(s_cmd_ready), 64'd0);
        @(negedge clk);
        chk("t2_full_cmd_valid", 64'(m_cmd_valid), 64'd0);
        m_src_valid = 1'b1;
        m_src_sop   = 1'b1;
        m_src_eop   = 1'b1;
        m_src_data  = 32'h0000_00F0;
        #1;
        chk("t2_pop_route", 64'(s_src_valid), 64'h1);
        chk("t2_pop_full_ready", 64'(s_cmd_ready), 64'd0);
        @(negedge clk);
        m_src_valid = 1'b0;
        #1;
        chk("t2_grant_after_pop", 64'(s_cmd_ready), 64'h1);
        @(negedge clk);
        s_cmd_valid = 4'd0;
        chk("t2_cmd_data_5th", 64'(m_cmd_data), 64'h0100);
        for (int k = 0; k < 4; k++) begin
            m_src_valid = 1'b1;
            #1;
            chk("t2_drain_route", 64'(s_src_valid), 64'(drain_own[k]));
            @(negedge clk);
        end
        src_idle();

        // Ch2 then ch0; 1-beat packet to ch2, 5-beat packet to ch0 with ready toggling
        set_cmd(2, 16'h0222);
        s_cmd_valid = 4'b0100;
        #1;
        chk("t3_grant_ch2", 64'(s_cmd_ready), 64'h4);
        @(negedge clk);
        set_cmd(0, 16'h0200);
        s_cmd_valid = 4'b0001;
        #1;
        chk("t3_grant_ch0", 64'(s_cmd_ready), 64'h1);
        chk("t3_cmd_data_ch2", 64'(m_cmd_data), 64'h0222);
        @(negedge clk);
        s_cmd_valid = 4'd0;
        chk("t3_cmd_data_ch0", 64'(m_cmd_data), 64'h0200);
        m_src_valid = 1'b1;
        m_src_sop   = 1'b1;
        m_src_eop   = 1'b1;
        m_src_data  = 32'h0000_00C0;
        #1;
        chk("t3_single_route", 64'(s_src_valid), 64'h4);
        @(negedge clk);
        b = 0;
        for (int c = 0; c < 7; c++) begin
            m_src_valid = 1'b1;
            m_src_data  = 32'h0000_00B0 + 32'(b);
            m_src_sop   = (b == 0);
            m_src_eop   = (b == 4);
            s_src_ready = {3'b111, rdy_pat[c]};
            #1;
            chk("t4_route", 64'(s_src_valid), 64'h1);
            chk("t4_ready_mirror", 64'(m_src_ready), 64'(rdy_pat[c]));
            chk("t4_data_order", 64'(s_src_data), 64'h00B0 + 64'(b));
            if (rdy_pat[c]) b++;
            @(negedge clk);
        end
        s_src_ready = 4'hF;
        src_idle();
        m_src_valid = 1'b1;
        m_src_sop   = 1'b1;
        #1;
        chk("t4_orphan_route", 64'(s_src_valid), 64'd0);
        chk("t4_orphan_stall", 64'(m_src_ready), 64'd0);
        src_idle();
        @(negedge clk);

        // Async reset mid-packet with 2 outstanding
        set_cmd(1, 16'h0111);
        set_cmd(3, 16'h0333);
        s_cmd_valid = 4'b1010;
        #1;
        chk("t5_grant_ch1", 64'(s_cmd_ready), 64'h2);
        @(negedge clk);
        s_cmd_valid = 4'b1000;
        #1;
        chk("t5_grant_ch3", 64'(s_cmd_ready), 64'h8);
        @(negedge clk);
        s_cmd_valid = 4'd0;
        m_cmd_ready = 1'b0;
        m_src_valid = 1'b1;
        m_src_sop   = 1'b1;
        m_src_data  = 32'h0000_00D0;
        #1;
        chk("t5_cmd_held", 64'(m_cmd_data), 64'h0333);
        chk("t5_beat0_route", 64'(s_src_valid), 64'h2);
        @(negedge clk);
        m_src_sop   = 1'b0;
        m_src_data  = 32'h0000_00D1;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_cmd_valid", 64'(m_cmd_valid), 64'd0);
        chk("t5_rst_cmd_data",  64'(m_cmd_data),  64'd0);
        chk("t5_rst_src_valid", 64'(s_src_valid), 64'd0);
        chk("t5_rst_src_ready", 64'(m_src_ready), 64'd0);
        chk("t5_rst_err",       64'(err),         64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_orphan_route", 64'(s_src_valid), 64'd0);
        chk("t5_orphan_stall", 64'(m_src_ready), 64'd0);
        @(negedge clk);
        chk("t5_orphan_err", 64'(err), 64'(EXP_ERR));
        @(negedge clk);
        chk("t5_orphan_err_sticky", 64'(err), 64'(EXP_ERR));
        src_idle();
        m_cmd_ready = 1'b1;

        // First beat without sop
        pulse_reset();
        #1;
        chk("t6_err_cleared", 64'(err), 64'd0);
        set_cmd(0, 16'h0A0A);
        s_cmd_valid = 4'b0001;
        @(negedge clk);
        s_cmd_valid = 4'd0;
        m_src_valid = 1'b1;
        m_src_sop   = 1'b0;
        m_src_eop   = 1'b1;
        m_src_data  = 32'h0000_00EE;
        #1;
        chk("t6_route", 64'(s_src_valid), 64'h1);
        chk("t6_ready", 64'(m_src_ready), 64'd1);
        @(negedge clk);
        src_idle();
        #1;
        chk("t6_err", 64'(err), 64'(EXP_ERR));
        chk("t6_popped", 64'(m_src_ready), 64'd0);
        @(negedge clk);
        chk("t6_err_sticky", 64'(err), 64'(EXP_ERR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
